decode_stage: RTL and testbench

- Instruction decode / operand-fetch stage for the RV32I core.
- Accepts fetched instructions with their PC and produces the exact operand bundle the execute ALU consumes: opcode, funct3, rs1/rs2 values, immediate, pc.
- Contains the integer register file, with a writeback write port and bypass.
- Output is a registered pipeline stage with a valid/ready handshake and a flush input.

---
 rtl/decode_stage_pkg.sv | 56 +++++
 rtl/decode_stage_if.sv | 36 +++
 rtl/decode_stage_regfile_2r1w.sv | 46 ++++
 rtl/decode_stage.sv | 113 +++++++++++
 tb/tb_decode_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants: opcodes, immediate formats, register index width
// and the operand bundle carried by the decode stage.
package decode_stage_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_R    = 3'd5,
        IMM_NONE = 3'd6
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1_idx;
        logic [REG_IDX_W-1:0] rs2_idx;
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc;
        logic                 illegal;
    } bundle_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_LUI, OPC_AUIPC:           fmt = IMM_U;
            OPC_JAL:                      fmt = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: fmt = IMM_I;
            OPC_BRANCH:                   fmt = IMM_B;
            OPC_STORE:                    fmt = IMM_S;
            OPC_OP:                       fmt = IMM_R;
            default:                      fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, writeback and execute-side signals of the decode stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [XLEN-1:0]      in_pc;
    logic                 flush;
    logic                 wb_en;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [6:0]           out_opcode;
    logic [2:0]           out_funct3;
    logic [REG_IDX_W-1:0] out_rd;
    logic [XLEN-1:0]      out_rs1;
    logic [XLEN-1:0]      out_rs2;
    logic [XLEN-1:0]      out_imm;
    logic [XLEN-1:0]      out_pc;
    logic                 out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_funct3, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_funct3, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );

endinterface

// File: rtl/decode_stage_regfile_2r1w.sv
// Integer register file: two combinational read ports that see a same-cycle
// write, one synchronous write port, x0 hard-wired to zero.
module regfile_2r1w
    import decode_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [XLEN-1:0]      rdata1,
    output logic [XLEN-1:0]      rdata2,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    // next array contents: one write per cycle, x0 kept at zero
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != 5'd0)) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d[0] = {XLEN{1'b0}};
        end
    end

    // array storage with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata1 = (raddr1 == 5'd0)             ? {XLEN{1'b0}} :
                    (we && (waddr == raddr1))    ? wdata : mem_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0)             ? {XLEN{1'b0}} :
                    (we && (waddr == raddr2))    ? wdata : mem_q[raddr2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage: one registered bundle slot with a
// valid/ready handshake, flush, and writeback refresh of a stalled bundle.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);

    logic            valid_q, valid_d;
    bundle_t         bundle_q, bundle_d;
    bundle_t         fresh_s;
    imm_fmt_e        fmt_s;
    logic [XLEN-1:0] rdata1_s, rdata2_s;
    logic            accept_s;

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
        logic [XLEN-1:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {i[31:12], 12'd0};
            IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_R:   imm = {25'd0, i[31:25]};
            default: imm = {XLEN{1'b0}};
        endcase
        return imm;
    endfunction

    regfile_2r1w u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (bus.in_instr[19:15]),
        .raddr2 (bus.in_instr[24:20]),
        .rdata1 (rdata1_s),
        .rdata2 (rdata2_s),
        .we     (bus.wb_en),
        .waddr  (bus.wb_rd),
        .wdata  (bus.wb_data)
    );

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept_s     = bus.in_valid && bus.in_ready && !bus.flush;

    // decode of the instruction currently offered by fetch
    always_comb begin
        fmt_s           = imm_fmt(bus.in_instr[6:0]);
        fresh_s         = '0;
        fresh_s.opcode  = bus.in_instr[6:0];
        fresh_s.funct3  = bus.in_instr[14:12];
        fresh_s.rs1_idx = bus.in_instr[19:15];
        fresh_s.rs2_idx = bus.in_instr[24:20];
        fresh_s.rs1     = rdata1_s;
        fresh_s.rs2     = rdata2_s;
        fresh_s.imm     = gen_imm(bus.in_instr, fmt_s);
        fresh_s.pc      = bus.in_pc;
        fresh_s.illegal = (fmt_s == IMM_NONE);
        if ((fmt_s == IMM_B) || (fmt_s == IMM_S)) begin
            fresh_s.rd = 5'd0;
        end else begin
            fresh_s.rd = bus.in_instr[11:7];
        end
    end

    // slot control: flush beats accept; a stalled bundle picks up writebacks
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d  = 1'b1;
            bundle_d = fresh_s;
        end else if (bus.in_ready) begin
            valid_d = 1'b0;
        end else begin
            if (bus.wb_en && (bus.wb_rd == bundle_q.rs1_idx) && (bundle_q.rs1_idx != 5'd0)) begin
                bundle_d.rs1 = bus.wb_data;
            end else begin
                bundle_d.rs1 = bundle_q.rs1;
            end
            if (bus.wb_en && (bus.wb_rd == bundle_q.rs2_idx) && (bundle_q.rs2_idx != 5'd0)) begin
                bundle_d.rs2 = bus.wb_data;
            end else begin
                bundle_d.rs2 = bundle_q.rs2;
            end
        end
    end

    // output slot register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_opcode  = bundle_q.opcode;
    assign bus.out_funct3  = bundle_q.funct3;
    assign bus.out_rd      = bundle_q.rd;
    assign bus.out_rs1     = bundle_q.rs1;
    assign bus.out_rs2     = bundle_q.rs2;
    assign bus.out_imm     = bundle_q.imm;
    assign bus.out_pc      = bundle_q.pc;
    assign bus.out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: an instruction-level reference model
// checked every cycle, plus hand-computed expectations for the directed vectors.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];
    logic        m_valid, m_zero, m_ill;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd, m_s1, m_s2;
    logic [31:0] m_rs1, m_rs2, m_imm, m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic [31:0] upper;
        upper = 32'hFFFF_FFFF << bits;
        if (v[bits-1]) return v | upper;
        else           return v & ~upper;
    endfunction

    function automatic logic [31:0] m_imm_of(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17:        return {i[31:12], 12'd0};
            7'h6F:               return sx({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            7'h67, 7'h03, 7'h13: return sx({20'd0, i[31:20]}, 12);
            7'h63:               return sx({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            7'h23:               return sx({20'd0, i[31:25], i[11:7]}, 12);
            7'h33:               return {25'd0, i[31:25]};
            default:             return 32'd0;
        endcase
    endfunction

    function automatic logic m_legal(input logic [6:0] op);
        return (op == 7'h37) || (op == 7'h17) || (op == 7'h6F) || (op == 7'h67) ||
               (op == 7'h63) || (op == 7'h03) || (op == 7'h23) || (op == 7'h13) || (op == 7'h33);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.wb_en && (bus.wb_rd == idx)) return bus.wb_data;
        return rf[idx];
    endfunction

    // reference model advanced at each edge, then compared against the DUT
    always @(posedge clk) begin : model_blk
        logic ready;
        m_zero = 1'b0;
        if (!rst_n) begin
            m_valid = 1'b0; m_zero = 1'b1; m_ill = 1'b0;
            m_op = 7'd0; m_f3 = 3'd0; m_rd = 5'd0; m_s1 = 5'd0; m_s2 = 5'd0;
            m_rs1 = 32'd0; m_rs2 = 32'd0; m_imm = 32'd0; m_pc = 32'd0;
            for (int k = 0; k < 32; k++) rf[k] = 32'd0;
        end else begin
            ready = !m_valid || bus.out_ready;
            if (bus.flush) begin
                m_valid = 1'b0;
            end else if (bus.in_valid && ready) begin
                m_valid = 1'b1;
                m_op  = bus.in_instr[6:0];
                m_f3  = bus.in_instr[14:12];
                m_s1  = bus.in_instr[19:15];
                m_s2  = bus.in_instr[24:20];
                m_rs1 = m_read(m_s1);
                m_rs2 = m_read(m_s2);
                m_imm = m_imm_of(bus.in_instr);
                m_pc  = bus.in_pc;
                m_ill = !m_legal(m_op);
                m_rd  = (m_op == 7'h63 || m_op == 7'h23) ? 5'd0 : bus.in_instr[11:7];
            end else if (ready) begin
                m_valid = 1'b0;
            end else begin
                if (bus.wb_en && bus.wb_rd == m_s1 && m_s1 != 5'd0) m_rs1 = bus.wb_data;
                if (bus.wb_en && bus.wb_rd == m_s2 && m_s2 != 5'd0) m_rs2 = bus.wb_data;
            end
            if (bus.wb_en && bus.wb_rd != 5'd0) rf[bus.wb_rd] = bus.wb_data;
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
        if (m_valid || m_zero) begin
            chk("opcode",  32'(bus.out_opcode), 32'(m_op));
            chk("funct3",  32'(bus.out_funct3), 32'(m_f3));
            chk("rd",      32'(bus.out_rd), 32'(m_rd));
            chk("rs1",     bus.out_rs1, m_rs1);
            chk("rs2",     bus.out_rs2, m_rs2);
            chk("imm",     bus.out_imm, m_imm);
            chk("pc",      bus.out_pc, m_pc);
            chk("illegal", 32'(bus.out_illegal), 32'(m_ill));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = rd;
        bus.wb_data = data;
    endtask

    logic [31:0] table_instr [6];

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0;
        bus.flush = 1'b0; bus.wb_en = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
        bus.out_ready = 1'b1;

        chk("model_imm_addi", m_imm_of(32'h00500093), 32'h0000_0005);
        chk("model_imm_sub",  m_imm_of(32'h402081B3), 32'h0000_0020);
        chk("model_imm_srai", m_imm_of(32'h4030D293), 32'h0000_0403);
        chk("model_imm_beq",  m_imm_of(32'hFE000EE3), 32'hFFFF_FFFC);
        chk("model_imm_lui",  m_imm_of(32'h123450B7), 32'h1234_5000);
        chk("model_imm_ill",  m_imm_of(32'h0000057F), 32'h0000_0000);

        tick(); tick();
        rst_n = 1'b1;

        offer(32'h00500093, 32'h100); tick(); bus.in_valid = 1'b0;
        chk("lit_addi_valid",  32'(bus.out_valid), 32'd1);
        chk("lit_addi_opcode", 32'(bus.out_opcode), 32'h13);
        chk("lit_addi_funct3", 32'(bus.out_funct3), 32'd0);
        chk("lit_addi_rd",     32'(bus.out_rd), 32'd1);
        chk("lit_addi_rs1",    bus.out_rs1, 32'd0);
        chk("lit_addi_imm",    bus.out_imm, 32'h5);
        chk("lit_addi_pc",     bus.out_pc, 32'h100);

        wb(5'd1, 32'd7); tick();
        wb(5'd2, 32'd3); tick();
        bus.wb_en = 1'b0;

        offer(32'h402081B3, 32'h104); tick();
        chk("lit_sub_rs1", bus.out_rs1, 32'd7);
        chk("lit_sub_rs2", bus.out_rs2, 32'd3);
        chk("lit_sub_imm", bus.out_imm, 32'h20);
        chk("lit_sub_rd",  32'(bus.out_rd), 32'd3);
        offer(32'h4030D293, 32'h108); tick();
        chk("lit_srai_imm", bus.out_imm, 32'h403);
        offer(32'hFE000EE3, 32'h10C); tick();
        chk("lit_beq_imm", bus.out_imm, 32'hFFFF_FFFC);
        chk("lit_beq_rd",  32'(bus.out_rd), 32'd0);
        offer(32'h123450B7, 32'h110); tick();
        chk("lit_lui_imm", bus.out_imm, 32'h1234_5000);

        table_instr[0] = 32'hFFDFF0EF; table_instr[1] = 32'h0020A423;
        table_instr[2] = 32'hFFFFF517; table_instr[3] = 32'h000080E7;
        table_instr[4] = 32'hFFC0A183; table_instr[5] = 32'h0000057F;
        for (int n = 0; n < 6; n++) begin
            offer(table_instr[n], 32'h200 + 32'(n * 4)); tick();
        end
        bus.in_valid = 1'b0;
        chk("lit_ill_flag",   32'(bus.out_illegal), 32'd1);
        chk("lit_ill_imm",    bus.out_imm, 32'd0);
        chk("lit_ill_opcode", 32'(bus.out_opcode), 32'h7F);

        wb(5'd1, 32'hDEADBEEF); offer(32'h00108233, 32'h300); tick();
        bus.wb_en = 1'b0;
        chk("lit_byp_rs1", bus.out_rs1, 32'hDEADBEEF);
        chk("lit_byp_rs2", bus.out_rs2, 32'hDEADBEEF);

        offer(32'h00108313, 32'h304); tick();
        bus.out_ready = 1'b0;
        offer(32'h00900393, 32'h308); tick();
        chk("lit_stall_ready", 32'(bus.in_ready), 32'd0);
        chk("lit_stall_rs1",   bus.out_rs1, 32'hDEADBEEF);
        wb(5'd1, 32'h11); tick();
        bus.wb_en = 1'b0;
        chk("lit_refresh_rs1", bus.out_rs1, 32'h11);
        tick();
        chk("lit_stall_pc", bus.out_pc, 32'h304);
        bus.out_ready = 1'b1; tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        wb(5'd0, 32'hFFFF_FFFF); tick();
        bus.wb_en = 1'b0;
        chk("lit_x0_rs1", bus.out_rs1, 32'd0);
        chk("lit_x0_rd",  32'(bus.out_rd), 32'd7);

        bus.out_ready = 1'b1; bus.flush = 1'b1;
        offer(32'h00200413, 32'h30C); tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("lit_flush_valid0", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lit_flush_valid1", 32'(bus.out_valid), 32'd0);

        offer(32'h00008493, 32'h400); tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; tick();
        chk("lit_pre_rst_rs1", bus.out_rs1, 32'h11);
        rst_n = 1'b0; tick();
        chk("lit_rst_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1; bus.out_ready = 1'b1;
        offer(32'h00008513, 32'h404); tick();
        bus.in_valid = 1'b0;
        chk("lit_post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("lit_post_rst_rs1",   bus.out_rs1, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
